// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative I-cache.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_INVAL
  } state_e;

  function automatic int log2c(input int v);
    return (v > 1) ? $clog2(v) : 0;
  endfunction

  function automatic int num_sets(input int cache, input int line,
                                  input int ways);
    return cache / line / ways;
  endfunction

  function automatic int idx_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int tag_w(input int aw, input int line,
                               input int sets);
    return aw - $clog2(line) - log2c(sets);
  endfunction

  function automatic int plru_bits(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                             input int line,
                                             input int sets);
    return (addr >> $clog2(line)) & 64'(sets - 1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                           input int line,
                                           input int sets);
    return addr >> ($clog2(line) + log2c(sets));
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and burst-memory-side signals of the I-cache.
interface icache_assoc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_ready;
  logic                  cpu_flush;
  logic                  cpu_fence_i;
  logic                  cpu_rvalid;
  logic [31:0]           cpu_rdata;
  logic                  mem_req;
  logic                  mem_gnt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_len;
  logic                  mem_rvalid;
  logic                  mem_rlast;
  logic [31:0]           mem_rdata;
  logic [CNT_WIDTH-1:0]  perf_hit_cnt;
  logic [CNT_WIDTH-1:0]  perf_miss_cnt;

  modport slave (
    input  cpu_req, cpu_addr, cpu_flush, cpu_fence_i,
    input  mem_gnt, mem_rvalid, mem_rlast, mem_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata,
    output mem_req, mem_addr, mem_len,
    output perf_hit_cnt, perf_miss_cnt
  );

  modport master (
    output cpu_req, cpu_addr, cpu_flush, cpu_fence_i,
    output mem_gnt, mem_rvalid, mem_rlast, mem_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata,
    input  mem_req, mem_addr, mem_len,
    input  perf_hit_cnt, perf_miss_cnt
  );
endinterface

// File: rtl/icache_plru.sv
// Tree pseudo-LRU: victim select and update-toward-way, no storage.
module icache_plru
  import icache_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  localparam int PB = plru_bits(NUM_WAYS),
  localparam int WW = way_w(NUM_WAYS)
) (
  input  logic [PB-1:0] tree,
  input  logic [WW-1:0] way,
  output logic [WW-1:0] victim,
  output logic [PB-1:0] tree_upd
);
  localparam int LV = log2c(NUM_WAYS);

  if (NUM_WAYS == 1) begin : g_one
    assign victim   = '0;
    assign tree_upd = tree;
  end else begin : g_tree
    // Node bit 0 points left, 1 points right; bits point at the LRU side.
    always_comb begin
      int node;
      node = 0;
      for (int l = 0; l < LV; l++)
        node = 2 * node + 1 + int'(tree[node]);
      victim = WW'(node - (NUM_WAYS - 1));
    end

    always_comb begin
      int   node;
      logic b;
      tree_upd = tree;
      node     = 0;
      b        = 1'b0;
      for (int l = 0; l < LV; l++) begin
        b              = way[LV-1-l];
        tree_upd[node] = ~b;
        node           = 2 * node + 1 + int'(b);
      end
    end
  end
endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative I-cache with PLRU, early restart and FENCE.I sweep.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int CACHE_SIZE = 4096,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input logic           clk,
  input logic           rst_n,
  icache_assoc_if.slave bus
);
  localparam int SETS = num_sets(CACHE_SIZE, LINE_SIZE, NUM_WAYS);
  localparam int IW   = idx_w(SETS);
  localparam int TW   = tag_w(ADDR_WIDTH, LINE_SIZE, SETS);
  localparam int OW   = $clog2(LINE_SIZE);
  localparam int WPL  = LINE_SIZE / 4;
  localparam int BW   = $clog2(WPL);
  localparam int PB   = plru_bits(NUM_WAYS);
  localparam int WW   = way_w(NUM_WAYS);

  state_e                state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  fence_pending;
  logic                  cancelled;
  logic [BW-1:0]         beat_cnt;
  logic [WW-1:0]         victim_q;
  logic [IW-1:0]         inval_cnt;
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_len_q;
  logic [CNT_WIDTH-1:0]  hit_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  logic [NUM_WAYS-1:0] valid_q [SETS];
  logic [PB-1:0]       plru_q  [SETS];
  logic [TW-1:0]       tag_q   [NUM_WAYS][SETS];
  logic [31:0]         data_q  [NUM_WAYS][SETS][WPL];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [BW-1:0] word;

  assign idx  = IW'(addr_index(64'(req_addr), LINE_SIZE, SETS));
  assign tag  = TW'(addr_tag(64'(req_addr), LINE_SIZE, SETS));
  assign word = req_addr[OW-1:2];

  logic          hit;
  logic          has_free;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] free_way;

  // Descending scan so the lowest-index match/free way wins.
  always_comb begin
    hit      = 1'b0;
    has_free = 1'b0;
    hit_way  = '0;
    free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        has_free = 1'b1;
        free_way = WW'(w);
      end
    end
  end

  logic [WW-1:0] upd_way;
  logic [WW-1:0] plru_victim;
  logic [PB-1:0] plru_next;

  assign upd_way = (state == S_LOOKUP) ? hit_way : victim_q;

  icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .tree     (plru_q[idx]),
    .way      (upd_way),
    .victim   (plru_victim),
    .tree_upd (plru_next)
  );

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic   fence_now;
  state_e done_st;

  assign fence_now = fence_pending | bus.cpu_fence_i;
  assign done_st   = fence_now ? S_INVAL : S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_addr      <= '0;
      fence_pending <= 1'b0;
      cancelled     <= 1'b0;
      beat_cnt      <= '0;
      victim_q      <= '0;
      inval_cnt     <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_len_q     <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      rvalid_q <= 1'b0;
      // A sweep in progress already covers any fence raised during it.
      if (bus.cpu_fence_i && state != S_IDLE && state != S_INVAL)
        fence_pending <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (fence_now) begin
            state <= S_INVAL;
          end else if (bus.cpu_req) begin
            req_addr <= bus.cpu_addr;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (bus.cpu_flush) begin
            state <= done_st;
          end else if (hit) begin
            rvalid_q    <= 1'b1;
            rdata_q     <= data_q[hit_way][idx][word];
            plru_q[idx] <= plru_next;
            hit_cnt     <= sat_inc(hit_cnt);
            state       <= done_st;
          end else begin
            victim_q   <= has_free ? free_way : plru_victim;
            miss_cnt   <= sat_inc(miss_cnt);
            mem_req_q  <= 1'b1;
            mem_addr_q <= {req_addr[ADDR_WIDTH-1:OW], OW'(0)};
            mem_len_q  <= 8'(WPL - 1);
            state      <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          // A grant commits the burst even if a flush arrives with it.
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            beat_cnt  <= '0;
            cancelled <= bus.cpu_flush;
            state     <= S_REFILL_DATA;
          end else if (bus.cpu_flush) begin
            mem_req_q <= 1'b0;
            state     <= done_st;
          end
        end
        S_REFILL_DATA: begin
          if (bus.cpu_flush)
            cancelled <= 1'b1;
          if (bus.mem_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == word && !cancelled && !bus.cpu_flush) begin
              rvalid_q <= 1'b1;
              rdata_q  <= bus.mem_rdata;
            end
            if (bus.mem_rlast) begin
              valid_q[idx][victim_q] <= 1'b1;
              plru_q[idx]            <= plru_next;
              cancelled              <= 1'b0;
              state                  <= done_st;
            end
          end
        end
        S_INVAL: begin
          valid_q[inval_cnt] <= '0;
          plru_q[inval_cnt]  <= '0;
          if (inval_cnt == IW'(SETS - 1)) begin
            inval_cnt     <= '0;
            fence_pending <= 1'b0;
            state         <= S_IDLE;
          end else begin
            inval_cnt <= inval_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_REFILL_DATA && bus.mem_rvalid) begin
      data_q[victim_q][idx][beat_cnt] <= bus.mem_rdata;
      if (bus.mem_rlast)
        tag_q[victim_q][idx] <= tag;
    end
  end

  assign bus.cpu_ready = (state == S_IDLE) && !fence_pending &&
                         !bus.cpu_fence_i;
  assign bus.cpu_rvalid    = rvalid_q;
  assign bus.cpu_rdata     = rdata_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_len       = mem_len_q;
  assign bus.perf_hit_cnt  = hit_cnt;
  assign bus.perf_miss_cnt = miss_cnt;
endmodule
